kinase_valve_sequencer: RTL and testbench

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

---
 rtl/kinase_seq_pkg.sv | 42 ++++
 rtl/peristaltic_pump_driver.sv | 52 +++++
 rtl/kinase_valve_sequencer.sv | 157 +++++++++++++++
 tb/tb_kinase_valve_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kinase_seq_pkg.sv
// Shared state encodings, valve masks and pump phase tables for the
// kinase valve sequencer and its peristaltic pump drivers.
package kinase_seq_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_A   = 3'd1;
  localparam logic [2:0] S_LOAD_B   = 3'd2;
  localparam logic [2:0] S_MIX      = 3'd3;
  localparam logic [2:0] S_INCUBATE = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int PA_W      = 3;
  localparam int PA_PHASES = 6;
  localparam int PB_W      = 2;
  localparam int PB_PHASES = 4;

  // Phase 0 sits in the least-significant slice of each table.
  localparam logic [PA_W*PA_PHASES-1:0] PUMP_A_TABLE =
    {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
  localparam logic [PB_W*PB_PHASES-1:0] PUMP_B_TABLE =
    {2'b00, 2'b01, 2'b11, 2'b10};

  typedef struct packed {
    logic [12:0] a;
    logic [3:0]  s;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input logic [2:0] st);
    ctrl_t c;
    case (st)
      S_LOAD_A:   c = '{a: 13'h1FFC, s: 4'hE};
      S_LOAD_B:   c = '{a: 13'h1FF3, s: 4'hD};
      S_MIX:      c = '{a: 13'h1F0F, s: 4'hB};
      S_INCUBATE: c = '{a: 13'h1FFF, s: 4'h7};
      S_FLUSH:    c = '{a: 13'h0000, s: 4'h0};
      default:    c = '{a: 13'h1FFF, s: 4'hF};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/peristaltic_pump_driver.sv
// Steps a pump through a phase table on each tick while enabled; idles with
// all lines high, or vents every line low when asked.
module peristaltic_pump_driver
  import kinase_seq_pkg::*;
#(
  parameter int W      = 3,
  parameter int PHASES = 6,
  parameter logic [W*PHASES-1:0] TABLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         tick,
  input  logic         vent,
  output logic [W-1:0] pattern,
  output logic         cycle_done
);

  localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic [W-1:0]    pattern_q, pattern_d;
  logic            last;

  assign last       = (phase_q == PH_W'(PHASES - 1));
  assign cycle_done = tick && last;
  assign pattern    = pattern_q;

  // enable describes the coming cycle, so the registered pattern lines up
  // with the sequencer state that takes effect on the same edge.
  always_comb begin
    phase_d = '0;
    if (enable) begin
      if (tick) phase_d = last ? '0 : phase_q + PH_W'(1);
      else      phase_d = phase_q;
    end
    pattern_d = '1;
    if (vent)        pattern_d = '0;
    else if (enable) pattern_d = TABLE[int'(phase_d)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      pattern_q <= '1;
    end else begin
      phase_q   <= phase_d;
      pattern_q <= pattern_d;
    end
  end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Run sequencer for the kinase assay chip: LOAD_A, LOAD_B, MIX, INCUBATE,
// FLUSH, DONE with registered valve and pump outputs.
module kinase_valve_sequencer
  import kinase_seq_pkg::*;
#(
  parameter int STEP_DIV    = 1000,
  parameter int FLUSH_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  load_a_cycles,
  input  logic [7:0]  load_b_cycles,
  input  logic [7:0]  mix_cycles,
  input  logic [15:0] incubate_steps,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_o,
  output logic [12:0] ctrl_a,
  output logic [3:0]  ctrl_s,
  output logic [2:0]  pump_a,
  output logic [1:0]  pump_b
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       la_q, la_d, lb_q, lb_d, mx_q, mx_d;
  logic [15:0]      inc_q, inc_d;
  ctrl_t            ctrl_q;
  logic             busy_q, done_q;

  logic count_state, tick;
  logic pa_en, pa_tick, pa_done;
  logic pb_en, pb_tick, pb_done;
  logic vent;

  // First state with a non-zero count strictly after 'from'.
  function automatic logic [2:0] next_run(input logic [2:0] from,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] m,
                                          input logic [15:0] n);
    logic [2:0] r;
    r = S_FLUSH;
    if (from <= S_MIX    && n != 16'd0) r = S_INCUBATE;
    if (from <= S_LOAD_B && m != 8'd0)  r = S_MIX;
    if (from <= S_LOAD_A && b != 8'd0)  r = S_LOAD_B;
    if (from == S_IDLE   && a != 8'd0)  r = S_LOAD_A;
    return r;
  endfunction

  assign count_state = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                       (state_q == S_MIX)    || (state_q == S_INCUBATE);
  assign tick        = count_state && (div_q == DIV_W'(STEP_DIV - 1));

  assign pa_en   = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
  assign pa_tick = tick && ((state_q == S_LOAD_A) || (state_q == S_LOAD_B));
  assign pb_en   = (state_d == S_MIX);
  assign pb_tick = tick && (state_q == S_MIX);
  assign vent    = (state_d == S_FLUSH);

  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    lb_d    = lb_q;
    mx_d    = mx_q;
    inc_d   = inc_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = next_run(S_IDLE, load_a_cycles, load_b_cycles, mix_cycles, incubate_steps);
        la_d    = load_a_cycles;
        lb_d    = load_b_cycles;
        mx_d    = mix_cycles;
        inc_d   = incubate_steps;
      end
      S_LOAD_A:   if (pa_done && (cnt_q + 16'd1 == {8'd0, la_q}))
                    state_d = next_run(S_LOAD_A, la_q, lb_q, mx_q, inc_q);
      S_LOAD_B:   if (pa_done && (cnt_q + 16'd1 == {8'd0, lb_q}))
                    state_d = next_run(S_LOAD_B, la_q, lb_q, mx_q, inc_q);
      S_MIX:      if (pb_done && (cnt_q + 16'd1 == {8'd0, mx_q}))
                    state_d = next_run(S_MIX, la_q, lb_q, mx_q, inc_q);
      S_INCUBATE: if (tick && (cnt_q + 16'd1 == inc_q)) state_d = S_FLUSH;
      S_FLUSH:    if (cnt_q == 16'(FLUSH_TICKS - 1)) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort && count_state) state_d = S_FLUSH;
  end

  // cnt_q counts pump cycles, incubate ticks or flush clocks in the current
  // state; both it and the divider restart on every state entry.
  always_comb begin
    div_d = '0;
    cnt_d = '0;
    if (state_d == state_q) begin
      if (count_state && !tick) div_d = div_q + DIV_W'(1);
      case (state_q)
        S_LOAD_A, S_LOAD_B: cnt_d = cnt_q + 16'(pa_done);
        S_MIX:              cnt_d = cnt_q + 16'(pb_done);
        S_INCUBATE:         cnt_d = cnt_q + 16'(tick);
        S_FLUSH:            cnt_d = cnt_q + 16'd1;
        default:            cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      la_q    <= '0;
      lb_q    <= '0;
      mx_q    <= '0;
      inc_q   <= '0;
      ctrl_q  <= ctrl_of(S_IDLE);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      mx_q    <= mx_d;
      inc_q   <= inc_d;
      ctrl_q  <= ctrl_of(state_d);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  peristaltic_pump_driver #(
    .W(PA_W), .PHASES(PA_PHASES), .TABLE(PUMP_A_TABLE)
  ) u_pump_a (
    .clk(clk), .rst(rst), .enable(pa_en), .tick(pa_tick), .vent(vent),
    .pattern(pump_a), .cycle_done(pa_done)
  );

  peristaltic_pump_driver #(
    .W(PB_W), .PHASES(PB_PHASES), .TABLE(PUMP_B_TABLE)
  ) u_pump_b (
    .clk(clk), .rst(rst), .enable(pb_en), .tick(pb_tick), .vent(vent),
    .pattern(pump_b), .cycle_done(pb_done)
  );

  assign state_o = state_q;
  assign ctrl_a  = ctrl_q.a;
  assign ctrl_s  = ctrl_q.s;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench: a run-plan model queues expected output frames, a
// monitor compares them against the sequencer every cycle.
module tb_kinase_valve_sequencer;

  localparam int STEP_DIV    = 4;
  localparam int FLUSH_TICKS = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  load_a_cycles, load_b_cycles, mix_cycles;
  logic [15:0] incubate_steps;
  logic        busy, done;
  logic [2:0]  state_o;
  logic [12:0] ctrl_a;
  logic [3:0]  ctrl_s;
  logic [2:0]  pump_a;
  logic [1:0]  pump_b;

  kinase_valve_sequencer #(.STEP_DIV(STEP_DIV), .FLUSH_TICKS(FLUSH_TICKS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_a_cycles(load_a_cycles), .load_b_cycles(load_b_cycles),
    .mix_cycles(mix_cycles), .incubate_steps(incubate_steps),
    .busy(busy), .done(done), .state_o(state_o),
    .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [12:0] ca;
    logic [3:0]  cs;
    logic [2:0]  pa;
    logic [1:0]  pb;
    logic        busy;
    logic        done;
  } frame_t;

  logic [12:0] ca_tab [0:6] = '{13'h1FFF, 13'h1FFC, 13'h1FF3, 13'h1F0F, 13'h1FFF, 13'h0000, 13'h1FFF};
  logic [3:0]  cs_tab [0:6] = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'h0, 4'hF};
  logic [2:0]  pa_seq [0:5] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0]  pb_seq [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};

  frame_t plan[$];
  frame_t exp_q[$];
  frame_t cur;
  int     n_pass = 0;
  int     n_chk  = 0;
  int     cyc    = 0;

  function automatic frame_t mk(input int st, input logic [2:0] pa, input logic [1:0] pb);
    frame_t f;
    f.st   = 3'(st);
    f.ca   = ca_tab[st];
    f.cs   = cs_tab[st];
    f.pa   = pa;
    f.pb   = pb;
    f.busy = (st != 0);
    f.done = (st == 6);
    return f;
  endfunction

  task automatic add_flush();
    for (int i = 0; i < FLUSH_TICKS; i++) plan.push_back(mk(5, 3'b000, 2'b00));
    plan.push_back(mk(6, 3'b111, 2'b11));
  endtask

  task automatic build_plan(input int a, input int b, input int m, input int n);
    plan.delete();
    for (int c = 0; c < a; c++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < STEP_DIV; k++) plan.push_back(mk(1, pa_seq[p], 2'b11));
    for (int c = 0; c < b; c++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < STEP_DIV; k++) plan.push_back(mk(2, pa_seq[p], 2'b11));
    for (int c = 0; c < m; c++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < STEP_DIV; k++) plan.push_back(mk(3, 3'b111, pb_seq[p]));
    for (int i = 0; i < n * STEP_DIV; i++) plan.push_back(mk(4, 3'b111, 2'b11));
    add_flush();
  endtask

  task automatic cycle(input logic r, input logic s, input logic ab,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] m, input logic [15:0] n);
    frame_t nxt;
    @(negedge clk);
    rst = r; start = s; abort = ab;
    load_a_cycles = a; load_b_cycles = b; mix_cycles = m; incubate_steps = n;
    if (r) begin
      plan.delete();
      nxt = mk(0, 3'b111, 2'b11);
    end else if (cur.st == 3'd0 && s) begin
      build_plan(int'(a), int'(b), int'(m), int'(n));
      nxt = plan.pop_front();
    end else if (ab && cur.st >= 3'd1 && cur.st <= 3'd4) begin
      plan.delete();
      add_flush();
      nxt = plan.pop_front();
    end else if (plan.size() != 0) begin
      nxt = plan.pop_front();
    end else begin
      nxt = mk(0, 3'b111, 2'b11);
    end
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  task automatic idle(input int n, input logic s = 1'b0);
    for (int i = 0; i < n; i++)
      cycle(1'b0, s, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
  endtask

  initial begin : monitor
    frame_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state_o), 32'(e.st));
        chk("ctrl",  {15'd0, ctrl_a, ctrl_s}, {15'd0, e.ca, e.cs});
        chk("pumps", {27'd0, pump_a, pump_b}, {27'd0, e.pa, e.pb});
        chk("flags", {30'd0, busy, done}, {30'd0, e.busy, e.done});
      end
    end
  end

  initial begin : stimulus
    cur = mk(0, 3'b111, 2'b11);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    load_a_cycles = '0; load_b_cycles = '0; mix_cycles = '0; incubate_steps = '0;

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
    idle(3);
    // abort in IDLE is ignored
    cycle(1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd1, 16'd1);

    // single LOAD_A cycle, counts changing afterwards must not matter
    cycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 16'd0);
    idle(95);

    // all counts zero: straight to FLUSH
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
    idle(70);

    // two MIX cycles with start pulses while busy
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd2, 16'd0);
    idle(10);
    cycle(1'b0, 1'b1, 1'b0, 8'd3, 8'd3, 8'd3, 16'd3);
    idle(100);

    // abort five clocks into MIX, starts during the flush are ignored
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd2, 16'd0);
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 16'd0);
    idle(10, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 16'd0);
    idle(70);

    // reset mid-INCUBATE, then a full run
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 16'd10);
    idle(15);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 16'd2);
    idle(160);

    // start and abort together in IDLE: start wins
    cycle(1'b0, 1'b1, 1'b1, 8'd0, 8'd1, 8'd0, 16'd1);
    idle(110);

    for (int i = 0; i < 6000; i++) begin
      logic r, s, ab;
      logic [7:0] a, b, m;
      logic [15:0] n;
      r  = ($urandom_range(0, 1499) == 0);
      s  = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 149) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 2));
      b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 2));
      m  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 2));
      n  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      cycle(r, s, ab, a, b, m, n);
    end

    idle(2);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
